// File: rtl/gcd_job_sequencer.sv
// Job feeder for a gcd core: buffers operand pairs in a small FIFO, issues one job at a time,
// waits for done (or a watchdog expiry) and presents the result with its operands on a valid/ready port.
module gcd_job_sequencer #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic                     out_timeout,
    output logic                     gcd_start,
    output logic [WIDTH-1:0]         gcd_a,
    output logic [WIDTH-1:0]         gcd_b,
    input  logic [WIDTH-1:0]         gcd_result,
    input  logic                     gcd_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_SAT  = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                 state_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [WD_W-1:0]        wd_reg;
    logic [2*WIDTH-1:0]     fifo_mem [DEPTH];
    logic [2*WIDTH-1:0]     head_word;
    logic                   push;
    logic                   pop;

    assign in_ready   = (count_reg < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign pop        = (state_reg == ST_IDLE) && (count_reg != '0);
    assign busy       = (count_reg != '0) || (state_reg != ST_IDLE);
    assign fifo_count = count_reg;
    assign head_word  = fifo_mem[rd_ptr_reg];

    // Storage carries data only; occupancy lives in the pointers and count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            wd_reg      <= '0;
            gcd_start   <= 1'b0;
            gcd_a       <= '0;
            gcd_b       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_timeout <= 1'b0;
        end else begin
            gcd_start <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        gcd_a     <= head_word[2*WIDTH-1:WIDTH];
                        gcd_b     <= head_word[WIDTH-1:0];
                        gcd_start <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // wd_reg==0 marks the first WAIT cycle, where a done left over from the previous job is ignored.
                    if ((wd_reg != '0) && gcd_done) begin
                        out_result  <= gcd_result;
                        out_timeout <= 1'b0;
                        out_a       <= gcd_a;
                        out_b       <= gcd_b;
                        out_valid   <= 1'b1;
                        state_reg   <= ST_HOLD;
                    end else if (wd_reg == WD_LAST) begin
                        out_result  <= '0;
                        out_timeout <= 1'b1;
                        out_a       <= gcd_a;
                        out_b       <= gcd_b;
                        out_valid   <= 1'b1;
                        state_reg   <= ST_HOLD;
                    end
                    if (wd_reg != WD_SAT) begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
